// File: rtl/pong_game_engine.sv
// Frame-rate Pong game-state engine: ball physics, paddles, scoring and match flow.
// All state advances on frame_tick except the single-clock POINT bookkeeping step.
module pong_game_engine #(
  parameter int FIELD_X_BEGIN      = 8,
  parameter int FIELD_X_END        = 631,
  parameter int FIELD_Y_BEGIN      = 8,
  parameter int FIELD_Y_END        = 471,
  parameter int BALL_RADIUS        = 4,
  parameter int PADDLE_RADIUS      = 32,
  parameter int PADDLE_THICKNESS   = 8,
  parameter int LEFT_PADDLE_BEGIN  = 24,
  parameter int RIGHT_PADDLE_BEGIN = 608,
  parameter int PADDLE_STEP        = 4,
  parameter int BALL_SPEED         = 2,
  parameter int SERVE_DELAY        = 60,
  parameter int WIN_SCORE          = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       left_up,
  input  logic       left_down,
  input  logic       right_up,
  input  logic       right_down,
  output logic [9:0] ball_loc_x,
  output logic [9:0] ball_loc_y,
  output logic [9:0] left_paddle_loc,
  output logic [9:0] right_paddle_loc,
  output logic [3:0] left_score,
  output logic [3:0] right_score,
  output logic [2:0] game_state,
  output logic       game_over
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SERVE     = 3'd1;
  localparam logic [2:0] ST_PLAY      = 3'd2;
  localparam logic [2:0] ST_POINT     = 3'd3;
  localparam logic [2:0] ST_GAME_OVER = 3'd4;

  localparam logic [9:0] CX         = 10'((FIELD_X_BEGIN + FIELD_X_END + 1) / 2);
  localparam logic [9:0] CY         = 10'((FIELD_Y_BEGIN + FIELD_Y_END + 1) / 2);
  localparam logic [9:0] PADDLE_MIN = 10'(FIELD_Y_BEGIN + PADDLE_RADIUS);
  localparam logic [9:0] PADDLE_MAX = 10'(FIELD_Y_END - PADDLE_RADIUS);
  localparam logic [9:0] STEP       = 10'(PADDLE_STEP);
  localparam logic [9:0] SPEED      = 10'(BALL_SPEED);
  localparam logic [9:0] REACH      = 10'(PADDLE_RADIUS + BALL_RADIUS);

  // Paddle-face windows for the ball centre, with the radius folded into the constant
  // so nothing is ever subtracted from a live position.
  localparam logic [9:0] L_FACE_LO  = 10'(LEFT_PADDLE_BEGIN + BALL_RADIUS);
  localparam logic [9:0] L_FACE_HI  = 10'(LEFT_PADDLE_BEGIN + PADDLE_THICKNESS + BALL_RADIUS);
  localparam logic [9:0] L_REBOUND  = 10'(LEFT_PADDLE_BEGIN + PADDLE_THICKNESS + BALL_RADIUS + 1);
  localparam logic [9:0] R_FACE_LO  = 10'(RIGHT_PADDLE_BEGIN - BALL_RADIUS);
  localparam logic [9:0] R_FACE_HI  = 10'(RIGHT_PADDLE_BEGIN + PADDLE_THICKNESS - BALL_RADIUS);
  localparam logic [9:0] R_REBOUND  = 10'(RIGHT_PADDLE_BEGIN - BALL_RADIUS - 1);
  localparam logic [9:0] L_MISS     = 10'(FIELD_X_BEGIN + BALL_SPEED + BALL_RADIUS);
  localparam logic [9:0] R_MISS     = 10'(FIELD_X_END - BALL_SPEED - BALL_RADIUS);
  localparam logic [9:0] TOP_BOUNCE = 10'(FIELD_Y_BEGIN + BALL_RADIUS + BALL_SPEED);
  localparam logic [9:0] TOP_CLAMP  = 10'(FIELD_Y_BEGIN + BALL_RADIUS);
  localparam logic [9:0] BOT_BOUNCE = 10'(FIELD_Y_END - BALL_RADIUS - BALL_SPEED);
  localparam logic [9:0] BOT_CLAMP  = 10'(FIELD_Y_END - BALL_RADIUS);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_DELAY - 1);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);

  logic [2:0] state, state_n;
  logic [9:0] bx, by, lp, rp;
  logic [9:0] bx_n, by_n, lp_n, rp_n;
  logic       dx, dy, dx_n, dy_n;
  logic [3:0] ls, rs, ls_n, rs_n;
  logic [7:0] cnt, cnt_n;
  logic       left_scored, left_scored_n;

  logic       left_hit, right_hit, left_miss, right_miss;
  logic       top_hit, bottom_hit;
  logic [9:0] lp_move, rp_move;
  logic [3:0] won_score;

  function automatic logic [9:0] paddle_next(input logic [9:0] p, input logic up,
                                             input logic down);
    logic [9:0] r;
    r = p;
    if (up && !down)
      r = (p <= PADDLE_MIN + STEP) ? PADDLE_MIN : p - STEP;
    else if (down && !up)
      r = (p + STEP >= PADDLE_MAX) ? PADDLE_MAX : p + STEP;
    return r;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

  // dx/dy are 1 for rightward/downward travel.
  assign left_hit   = !dx && (bx >= L_FACE_LO) && (bx <= L_FACE_HI) &&
                      (by <= lp + REACH) && (lp <= by + REACH);
  assign right_hit  = dx && (bx >= R_FACE_LO) && (bx <= R_FACE_HI) &&
                      (by <= rp + REACH) && (rp <= by + REACH);
  assign left_miss  = !dx && (bx <= L_MISS);
  assign right_miss = dx && (bx >= R_MISS);
  assign top_hit    = !dy && (by <= TOP_BOUNCE);
  assign bottom_hit = dy && (by >= BOT_BOUNCE);

  assign lp_move    = paddle_next(lp, left_up, left_down);
  assign rp_move    = paddle_next(rp, right_up, right_down);
  assign won_score  = left_scored ? sat_inc(ls) : sat_inc(rs);

  always_comb begin
    state_n       = state;
    bx_n          = bx;
    by_n          = by;
    lp_n          = lp;
    rp_n          = rp;
    dx_n          = dx;
    dy_n          = dy;
    ls_n          = ls;
    rs_n          = rs;
    cnt_n         = cnt;
    left_scored_n = left_scored;

    case (state)
      ST_IDLE, ST_GAME_OVER: begin
        if (frame_tick && start) begin
          ls_n    = 4'd0;
          rs_n    = 4'd0;
          bx_n    = CX;
          by_n    = CY;
          cnt_n   = 8'd0;
          state_n = ST_SERVE;
        end
      end

      ST_SERVE: begin
        if (frame_tick) begin
          lp_n = lp_move;
          rp_n = rp_move;
          if (cnt == SERVE_LAST) begin
            cnt_n   = 8'd0;
            state_n = ST_PLAY;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end

      ST_PLAY: begin
        if (frame_tick) begin
          lp_n = lp_move;
          rp_n = rp_move;
          if (left_hit) begin
            bx_n = L_REBOUND;
            dx_n = 1'b1;
          end else if (right_hit) begin
            bx_n = R_REBOUND;
            dx_n = 1'b0;
          end else if (left_miss) begin
            left_scored_n = 1'b0;
            state_n       = ST_POINT;
          end else if (right_miss) begin
            left_scored_n = 1'b1;
            state_n       = ST_POINT;
          end else begin
            bx_n = dx ? bx + SPEED : bx - SPEED;
          end

          // A miss freezes the ball where it is; POINT recentres it next clock.
          if (!left_miss && !right_miss) begin
            if (top_hit) begin
              by_n = TOP_CLAMP;
              dy_n = 1'b1;
            end else if (bottom_hit) begin
              by_n = BOT_CLAMP;
              dy_n = 1'b0;
            end else begin
              by_n = dy ? by + SPEED : by - SPEED;
            end
          end
        end
      end

      ST_POINT: begin
        if (left_scored) ls_n = won_score;
        else             rs_n = won_score;
        if (won_score == WIN) begin
          state_n = ST_GAME_OVER;
        end else begin
          bx_n    = CX;
          by_n    = CY;
          dx_n    = left_scored;
          dy_n    = !dy;
          cnt_n   = 8'd0;
          state_n = ST_SERVE;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      bx          <= CX;
      by          <= CY;
      lp          <= CY;
      rp          <= CY;
      dx          <= 1'b1;
      dy          <= 1'b1;
      ls          <= 4'd0;
      rs          <= 4'd0;
      cnt         <= 8'd0;
      left_scored <= 1'b0;
    end else begin
      state       <= state_n;
      bx          <= bx_n;
      by          <= by_n;
      lp          <= lp_n;
      rp          <= rp_n;
      dx          <= dx_n;
      dy          <= dy_n;
      ls          <= ls_n;
      rs          <= rs_n;
      cnt         <= cnt_n;
      left_scored <= left_scored_n;
    end
  end

  assign ball_loc_x       = bx;
  assign ball_loc_y       = by;
  assign left_paddle_loc  = lp;
  assign right_paddle_loc = rp;
  assign left_score       = ls;
  assign right_score      = rs;
  assign game_state       = state;
  assign game_over        = (state == ST_GAME_OVER);

endmodule

// File: tb/tb_pong_game_engine.sv
// Bench for pong_game_engine: a signed-integer game model checked every clock,
// plus literal expectations taken from hand-traced ball trajectories.
module tb_pong_game_engine;

  localparam int CX = 320, CY = 240;
  localparam int BR = 4, PR = 32, PT = 8, LPB = 24, RPB = 608;
  localparam int FXB = 8, FXE = 631, FYB = 8, FYE = 471;
  localparam int STEP = 4, SPEED = 2, DELAY = 60, WIN = 9;
  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_POINT = 3, M_OVER = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_tick = 1'b0;
  logic start = 1'b0;
  logic left_up = 1'b0, left_down = 1'b0, right_up = 1'b0, right_down = 1'b0;
  logic [9:0] ball_loc_x, ball_loc_y, left_paddle_loc, right_paddle_loc;
  logic [3:0] left_score, right_score;
  logic [2:0] game_state;
  logic game_over;

  int checks = 0;
  int failures = 0;

  int m_bx, m_by, m_vx, m_vy, m_lp, m_rp, m_ls, m_rs, m_state, m_cnt;
  bit m_left_scored;

  always #5 clk = ~clk;

  pong_game_engine dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .left_up(left_up), .left_down(left_down), .right_up(right_up), .right_down(right_down),
    .ball_loc_x(ball_loc_x), .ball_loc_y(ball_loc_y),
    .left_paddle_loc(left_paddle_loc), .right_paddle_loc(right_paddle_loc),
    .left_score(left_score), .right_score(right_score),
    .game_state(game_state), .game_over(game_over)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int movePaddle(input int p, input bit up, input bit down);
    if (up && !down) return (p - STEP < FYB + PR) ? FYB + PR : p - STEP;
    if (down && !up) return (p + STEP > FYE - PR) ? FYE - PR : p + STEP;
    return p;
  endfunction

  task automatic modelReset();
    m_bx = CX; m_by = CY; m_vx = SPEED; m_vy = SPEED;
    m_lp = CY; m_rp = CY; m_ls = 0; m_rs = 0;
    m_state = M_IDLE; m_cnt = 0; m_left_scored = 0;
  endtask

  // One clock of game rules, using the paddle positions from before this frame's move.
  task automatic modelTick();
    int lp_old, rp_old, won;
    bit miss;
    lp_old = m_lp;
    rp_old = m_rp;
    miss = 0;
    if (m_state == M_POINT) begin
      won = m_left_scored ? m_ls + 1 : m_rs + 1;
      if (won > 15) won = 15;
      if (m_left_scored) m_ls = won; else m_rs = won;
      if (won == WIN) m_state = M_OVER;
      else begin
        m_bx = CX; m_by = CY; m_cnt = 0;
        m_vx = m_left_scored ? SPEED : -SPEED;
        m_vy = -m_vy;
        m_state = M_SERVE;
      end
    end else if (frame_tick) begin
      if (m_state == M_IDLE || m_state == M_OVER) begin
        if (start) begin
          m_ls = 0; m_rs = 0; m_bx = CX; m_by = CY; m_cnt = 0; m_state = M_SERVE;
        end
      end else if (m_state == M_SERVE) begin
        m_lp = movePaddle(m_lp, left_up, left_down);
        m_rp = movePaddle(m_rp, right_up, right_down);
        if (m_cnt == DELAY - 1) begin m_cnt = 0; m_state = M_PLAY; end
        else m_cnt++;
      end else if (m_state == M_PLAY) begin
        m_lp = movePaddle(m_lp, left_up, left_down);
        m_rp = movePaddle(m_rp, right_up, right_down);
        if (m_vx < 0 && m_bx - BR <= LPB + PT && m_bx - BR >= LPB && iabs(m_by - lp_old) <= PR + BR) begin
          m_bx = LPB + PT + BR + 1; m_vx = SPEED;
        end else if (m_vx > 0 && m_bx + BR >= RPB && m_bx + BR <= RPB + PT && iabs(m_by - rp_old) <= PR + BR) begin
          m_bx = RPB - BR - 1; m_vx = -SPEED;
        end else if (m_vx < 0 && m_bx - BR <= FXB + SPEED) begin
          miss = 1; m_left_scored = 0; m_state = M_POINT;
        end else if (m_vx > 0 && m_bx + BR >= FXE - SPEED) begin
          miss = 1; m_left_scored = 1; m_state = M_POINT;
        end else m_bx = m_bx + m_vx;
        if (!miss) begin
          if (m_vy < 0 && m_by <= FYB + BR + SPEED) begin m_by = FYB + BR; m_vy = SPEED; end
          else if (m_vy > 0 && m_by >= FYE - BR - SPEED) begin m_by = FYE - BR; m_vy = -SPEED; end
          else m_by = m_by + m_vy;
        end
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) modelReset();
    else modelTick();
  end

  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("ball_x", ball_loc_x, m_bx);
      checkOutput("ball_y", ball_loc_y, m_by);
      checkOutput("left_paddle", left_paddle_loc, m_lp);
      checkOutput("right_paddle", right_paddle_loc, m_rp);
      checkOutput("left_score", left_score, m_ls);
      checkOutput("right_score", right_score, m_rs);
      checkOutput("game_state", game_state, m_state);
      checkOutput("game_over", game_over, m_state == M_OVER);
    end
  end

  // Called at a falling edge; pulses frame_tick for one clock then idles gap clocks.
  task automatic applyStimulus(input bit st, input bit lu, input bit ld, input bit ru,
                               input bit rd, input int gap);
    start = st; left_up = lu; left_down = ld; right_up = ru; right_down = rd;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    start = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ball_x"}, ball_loc_x, 320);
    checkOutput({tag, "_ball_y"}, ball_loc_y, 240);
    checkOutput({tag, "_left_paddle"}, left_paddle_loc, 240);
    checkOutput({tag, "_right_paddle"}, right_paddle_loc, 240);
    checkOutput({tag, "_left_score"}, left_score, 0);
    checkOutput({tag, "_right_score"}, right_score, 0);
    checkOutput({tag, "_state"}, game_state, 0);
    checkOutput({tag, "_game_over"}, game_over, 0);
  endtask

  initial begin
    int budget;
    bit lu, ld;
    repeat (2) @(negedge clk);
    checkResetValues("por");
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_state", game_state, 0);

    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("serve_entry_state", game_state, 1);
    for (int i = 1; i <= DELAY; i++) begin
      applyStimulus(0, 1, 0, 1, 0, 1);
      if (i == 1) checkOutput("left_paddle_first_step", left_paddle_loc, 236);
      if (i == 59) checkOutput("serve_still_state", game_state, 1);
    end
    checkOutput("play_state", game_state, 2);
    checkOutput("left_paddle_clamped", left_paddle_loc, 40);
    checkOutput("right_paddle_clamped", right_paddle_loc, 40);
    checkOutput("serve_ball_x", ball_loc_x, 320);

    // Ball leaves toward the right wall, bounces off the bottom and slips past the top-pinned right paddle.
    for (int n = 1; n <= 153; n++) begin
      applyStimulus(0, n > 10, 1, 1, 0, 1);
      if (n == 1) begin
        checkOutput("first_move_x", ball_loc_x, 322);
        checkOutput("first_move_y", ball_loc_y, 242);
        checkOutput("left_paddle_down", left_paddle_loc, 44);
        checkOutput("model_pin_x", m_bx, 322);
      end
      if (n == 10) checkOutput("left_paddle_80", left_paddle_loc, 80);
      if (n == 50) checkOutput("both_buttons_hold", left_paddle_loc, 80);
      if (n == 113) checkOutput("pre_bottom_y", ball_loc_y, 466);
      if (n == 114) begin
        checkOutput("bottom_clamp_y", ball_loc_y, 467);
        checkOutput("bottom_clamp_x", ball_loc_x, 548);
      end
      if (n == 115) checkOutput("after_bottom_y", ball_loc_y, 465);
      if (n == 153) begin
        checkOutput("pre_miss_x", ball_loc_x, 626);
        checkOutput("pre_miss_y", ball_loc_y, 389);
        checkOutput("pre_miss_state", game_state, 2);
      end
    end
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("point_state", game_state, 3);
    checkOutput("point_score_pending", left_score, 0);
    @(negedge clk);
    checkOutput("after_point_state", game_state, 1);
    checkOutput("after_point_left_score", left_score, 1);
    checkOutput("after_point_right_score", right_score, 0);
    checkOutput("recentre_x", ball_loc_x, 320);
    checkOutput("recentre_y", ball_loc_y, 240);

    // Back-to-back ticks: each later point repeats the same path and a tick lands on every POINT clock.
    for (budget = 0; budget < 4000 && m_state != M_OVER; budget++)
      applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("reached_game_over", game_over, 1);
    checkOutput("final_left_score", left_score, 9);
    checkOutput("final_right_score", right_score, 0);
    checkOutput("over_state", game_state, 4);
    checkOutput("model_pin_score", m_ls, 9);
    repeat (5) applyStimulus(0, 1, 0, 0, 1, 1);
    checkOutput("frozen_x", ball_loc_x, 626);
    checkOutput("frozen_y", ball_loc_y, 389);
    checkOutput("frozen_left_paddle", left_paddle_loc, 80);
    checkOutput("frozen_right_paddle", right_paddle_loc, 40);

    // Restart keeps dx=+ and dy=- from the last rally: top bounce then a right-paddle return.
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("restart_state", game_state, 1);
    checkOutput("restart_left_score", left_score, 0);
    checkOutput("restart_ball_x", ball_loc_x, 320);
    for (int i = 1; i <= DELAY + 450; i++) begin
      lu = (m_lp > m_by + 2);
      ld = (m_lp < m_by - 2);
      applyStimulus(0, lu, ld, 1, 0, 1);
      if (i == DELAY + 113) begin
        checkOutput("near_top_y", ball_loc_y, 14);
        checkOutput("near_top_x", ball_loc_x, 546);
      end
      if (i == DELAY + 114) checkOutput("top_clamp_y", ball_loc_y, 12);
      if (i == DELAY + 115) checkOutput("after_top_y", ball_loc_y, 14);
      if (i == DELAY + 143) checkOutput("right_hit_x", ball_loc_x, 603);
      if (i == DELAY + 144) checkOutput("after_right_hit_x", ball_loc_x, 601);
    end

    checkOutput("pre_reset_state", game_state, 2);
    #2 reset = 1'b1;
    @(negedge clk);
    checkResetValues("mid_reset");
    reset = 1'b0;
    applyStimulus(0, 1, 0, 0, 1, 1);
    checkOutput("idle_frozen_left", left_paddle_loc, 240);
    checkOutput("idle_frozen_right", right_paddle_loc, 240);
    checkOutput("idle_after_reset", game_state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
